// File: rtl/eth_tx_frame_arb.sv
// Frame-level round-robin arbiter sharing one 8-bit AXI-Stream GMII TX path between S_COUNT sources.
// Latency: 1 cycle from tvalid to grant, then zero-latency combinational pass-through of the granted port.
// Backpressure: m_axis_tready is routed only to the granted source; all others see tready=0.
// Optional stall watchdog is enabled with `define ETH_TX_ARB_WATCHDOG_EN (terminates and drains a stalled frame).
module eth_tx_frame_arb #(
  parameter int S_COUNT         = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int USER_WIDTH      = 1,
  parameter int WATCHDOG_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_COUNT-1:0]            s_axis_tvalid,
  output logic [S_COUNT-1:0]            s_axis_tready,
  input  logic [S_COUNT-1:0]            s_axis_tlast,
  input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  input  logic                          enable,
  output logic [S_COUNT-1:0]            grant,
  output logic                          grant_valid,
  output logic [$clog2(S_COUNT)-1:0]    grant_encoded,
  output logic                          frame_done,
  output logic                          watchdog_abort
);

  localparam int IDX_W = $clog2(S_COUNT);

  // Configurations the index/counter widths cannot represent are rejected at elaboration.
  if (S_COUNT < 2 || S_COUNT > 16 || WATCHDOG_CYCLES < 1 || WATCHDOG_CYCLES > 65535) begin : g_bad_params
    $error("eth_tx_frame_arb: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, XFER, TERM, DROP} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_vld;
  logic [IDX_W-1:0] next_ptr;
  logic             g_vld;
  logic             g_last;

  assign g_vld    = s_axis_tvalid[grant_encoded];
  assign g_last   = s_axis_tlast[grant_encoded];
  assign next_ptr = (grant_encoded == IDX_W'(S_COUNT - 1)) ? '0 : grant_encoded + 1'b1;

  // Round-robin pick: first requester at or above the pointer, wrapping.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = 0; k < S_COUNT; k++) begin
      cand = IDX_W'((int'(ptr) + k) % S_COUNT);
      if (!sel_vld && s_axis_tvalid[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

  // Datapath mux and ready steering for the granted port.
  always_comb begin
    m_axis_tdata  = s_axis_tdata[int'(grant_encoded)*DATA_WIDTH +: DATA_WIDTH];
    m_axis_tuser  = s_axis_tuser[int'(grant_encoded)*USER_WIDTH +: USER_WIDTH];
    m_axis_tlast  = g_last;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    case (state)
      XFER: begin
        m_axis_tvalid                = g_vld;
        s_axis_tready[grant_encoded] = m_axis_tready;
      end
`ifdef ETH_TX_ARB_WATCHDOG_EN
      // Synthesized error-terminated beat so the framer closes the frame cleanly.
      TERM: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b1;
        m_axis_tuser  = USER_WIDTH'(1);
      end
      // Swallow the rest of the stalled frame so the source realigns on tlast.
      DROP: s_axis_tready[grant_encoded] = 1'b1;
`endif
      default: ;
    endcase
  end

`ifdef ETH_TX_ARB_WATCHDOG_EN
  logic [15:0] stall_cnt;
`else
  assign watchdog_abort = 1'b0;
`endif

  // Grant FSM: grant in IDLE, hold for a whole frame, release and rotate after tlast.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      grant         <= '0;
      grant_valid   <= 1'b0;
      grant_encoded <= '0;
      ptr           <= '0;
      frame_done    <= 1'b0;
`ifdef ETH_TX_ARB_WATCHDOG_EN
      stall_cnt      <= '0;
      watchdog_abort <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
`ifdef ETH_TX_ARB_WATCHDOG_EN
      watchdog_abort <= 1'b0;
      stall_cnt      <= '0;
`endif
      case (state)
        IDLE: begin
          if (enable && sel_vld) begin
            grant         <= S_COUNT'(1) << sel_idx;
            grant_encoded <= sel_idx;
            grant_valid   <= 1'b1;
            state         <= XFER;
          end
        end
        XFER: begin
          if (g_vld && m_axis_tready && g_last) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            ptr         <= next_ptr;
            frame_done  <= 1'b1;
          end
`ifdef ETH_TX_ARB_WATCHDOG_EN
          else if (!g_vld && stall_cnt == 16'(WATCHDOG_CYCLES - 1)) begin
            state <= TERM;
          end
          stall_cnt <= g_vld ? '0 : stall_cnt + 1'b1;
`endif
        end
`ifdef ETH_TX_ARB_WATCHDOG_EN
        TERM: begin
          if (m_axis_tready) begin
            state          <= DROP;
            watchdog_abort <= 1'b1;
          end
        end
        DROP: begin
          if (g_vld && g_last) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            ptr         <= next_ptr;
            frame_done  <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_frame_arb.sv
// Bench for eth_tx_frame_arb: per-port frame sources, expected beat/grant scoreboard, decoupled monitor.
// Stimulus is driven 1 time unit after posedge; monitor samples on negedge.
// Backpressure exercised via constant and toggling m_axis_tready.
module tb_eth_tx_frame_arb;
  localparam int S  = 4;
  localparam int DW = 8;
  localparam int UW = 1;
  localparam int WD = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [S*DW-1:0] s_axis_tdata;
  logic [S-1:0]  s_axis_tvalid;
  logic [S-1:0]  s_axis_tready;
  logic [S-1:0]  s_axis_tlast;
  logic [S*UW-1:0] s_axis_tuser;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [UW-1:0] m_axis_tuser;
  logic          enable;
  logic [S-1:0]  grant;
  logic          grant_valid;
  logic [1:0]    grant_encoded;
  logic          frame_done;
  logic          watchdog_abort;

  always #5 clk = ~clk;

  eth_tx_frame_arb #(
    .S_COUNT(S), .DATA_WIDTH(DW), .USER_WIDTH(UW), .WATCHDOG_CYCLES(WD)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .enable(enable), .grant(grant), .grant_valid(grant_valid), .grant_encoded(grant_encoded),
    .frame_done(frame_done), .watchdog_abort(watchdog_abort)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Per-port source memories: entry = {tuser, tlast, tdata}.
  logic [9:0] mem [S][256];
  int wr [S] = '{default: 0};
  int rd [S] = '{default: 0};
  int sent [S] = '{default: 0};
  int hold_after [S] = '{default: -1};
  bit tr_toggle = 1'b0;

  // Scoreboard queues.
  logic [9:0] expq [$];
  int expg [$];
  int expgap [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] beat_dat(input int p, input int b);
    return 8'((p * 64) + (b % 64));
  endfunction

  task automatic push_src(input int p, input int len, input int base);
    for (int k = 0; k < len; k++) begin
      mem[p][wr[p] % 256] = {1'b0, (k == len - 1), beat_dat(p, base + k)};
      wr[p]++;
    end
  endtask

  task automatic push_exp(input int p, input int len, input int base);
    for (int k = 0; k < len; k++)
      expq.push_back({1'b0, (k == len - 1), beat_dat(p, base + k)});
  endtask

  task automatic push_grant(input int p, input int gap);
    expg.push_back(p);
    expgap.push_back(gap);
  endtask

  task automatic wait_done(input int lim);
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (frame_done) break;
    end
    chk("frame_done_seen", 32'(frame_done), 32'd1);
  endtask

  task automatic wait_grant(input int lim);
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if (grant_valid) break;
    end
    chk("grant_seen", 32'(grant_valid), 32'd1);
  endtask

  task automatic wait_drain(input int lim);
    for (int k = 0; k < lim; k++) begin
      if (expq.size() == 0 && expg.size() == 0) break;
      @(negedge clk);
    end
    chk("scoreboard_drained", 32'(expq.size() + expg.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // Source driver: pops accepted beats and presents the next one.
  initial begin
    logic [S-1:0] acc;
    logic         has;
    logic [9:0]   ent;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tuser  = '0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    forever begin
      @(negedge clk);
      acc = s_axis_tvalid & s_axis_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < S; i++) begin
        if (acc[i]) begin
          rd[i]++;
          sent[i]++;
        end
      end
      m_axis_tready = tr_toggle ? ~m_axis_tready : 1'b1;
      for (int i = 0; i < S; i++) begin
        has = (rd[i] != wr[i]) && (hold_after[i] < 0 || sent[i] < hold_after[i]);
        ent = has ? mem[i][rd[i] % 256] : 10'd0;
        s_axis_tvalid[i]          = has;
        s_axis_tlast[i]           = ent[8];
        s_axis_tuser[i]           = ent[9];
        s_axis_tdata[i*DW +: DW]  = ent[7:0];
      end
    end
  end

  // Monitor: compares output beats, grants, frame_done and ready steering.
  initial begin
    logic       gv_prev;
    logic       last_prev;
    int         idle_run;
    int         cur_p;
    int         p;
    int         g;
    logic [9:0] e;
    gv_prev   = 1'b0;
    last_prev = 1'b0;
    idle_run  = 0;
    cur_p     = 0;
    forever begin
      @(negedge clk);
      if (m_axis_tvalid && m_axis_tready) begin
        if (expq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL m_beat_unexpected: got 0x%0h, expected no beat at t=%0t",
                   {m_axis_tuser, m_axis_tlast, m_axis_tdata}, $time);
        end else begin
          e = expq.pop_front();
          chk("m_beat", 32'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 32'(e));
        end
      end
      if (grant_valid && !gv_prev) begin
        if (expg.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL grant_unexpected: got 0x%0h, expected no grant at t=%0t", grant, $time);
        end else begin
          p = expg.pop_front();
          g = expgap.pop_front();
          cur_p = p;
          chk("grant_onehot", 32'(grant), 32'd1 << p);
          chk("grant_encoded", 32'(grant_encoded), 32'(p));
          if (g >= 0) chk("idle_gap", 32'(idle_run), 32'(g));
        end
      end
      idle_run = grant_valid ? 0 : idle_run + 1;
      if (frame_done || last_prev) begin
        chk("frame_done_pulse", 32'(frame_done), 32'(last_prev));
        chk("frame_done_gv_low", 32'(grant_valid), 32'd0);
      end
`ifndef ETH_TX_ARB_WATCHDOG_EN
      chk("s_tready_steer", 32'(s_axis_tready),
          grant_valid ? (32'(m_axis_tready) << cur_p) : 32'd0);
`endif
      last_prev = (|(s_axis_tvalid & s_axis_tready & s_axis_tlast)) && !rst;
      gv_prev   = grant_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish before t=500000");
    $fatal(1, "timeout");
  end

  // Directed sequence.
  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_grant_valid", 32'(grant_valid), 32'd0);
    chk("rst_grant_encoded", 32'(grant_encoded), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_watchdog_abort", 32'(watchdog_abort), 32'd0);
    chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Port 1, 64-beat frame, one-cycle arbitration.
    @(negedge clk);
    push_grant(1, -1);
    push_src(1, 64, 0);
    push_exp(1, 64, 0);
    @(negedge clk);
    chk("arb_latency_idle", 32'(grant_valid), 32'd0);
    @(negedge clk);
    chk("arb_latency_grant", 32'(grant), 32'b0010);
    wait_done(200);
    @(negedge clk);
    chk("post_frame_gv", 32'(grant_valid), 32'd0);
    wait_drain(50);

    // Reset pointer to 0, then ports 0,2,3 request continuously.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    push_src(0, 10, 0);  push_src(0, 10, 10);
    push_src(2, 10, 0);  push_src(2, 10, 10);
    push_src(3, 10, 0);  push_src(3, 10, 10);
    push_exp(0, 10, 0);  push_exp(2, 10, 0);  push_exp(3, 10, 0);
    push_exp(0, 10, 10); push_exp(2, 10, 10); push_exp(3, 10, 10);
    push_grant(0, -1); push_grant(2, 1); push_grant(3, 1);
    push_grant(0, 1);  push_grant(2, 1); push_grant(3, 1);
    wait_drain(400);

    // Port 2 under toggling m_axis_tready.
    tr_toggle = 1'b1;
    push_grant(2, -1);
    push_src(2, 10, 20);
    push_exp(2, 10, 20);
    wait_drain(100);
    tr_toggle = 1'b0;
    repeat (2) @(negedge clk);

    // enable drops while port 0 is mid-frame; port 1 waits for enable.
    push_grant(0, -1);
    push_src(0, 20, 20);
    push_exp(0, 20, 20);
    wait_grant(20);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    push_grant(1, -1);
    push_src(1, 5, 0);
    push_exp(1, 5, 0);
    wait_done(100);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("enable_hold", 32'(grant_valid), 32'd0);
    end
    @(posedge clk); #1 enable = 1'b1;
    @(negedge clk);
    chk("enable_latency_idle", 32'(grant_valid), 32'd0);
    @(negedge clk);
    chk("enable_latency_grant", 32'(grant), 32'b0010);
    wait_drain(50);

    // Reset in the middle of a port 3 frame; pointer returns to 0.
    push_grant(3, -1);
    push_src(3, 30, 0);
    push_exp(3, 30, 0);
    wait_grant(20);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_grant_valid", 32'(grant_valid), 32'd0);
    chk("midrst_grant_encoded", 32'(grant_encoded), 32'd0);
    rd[3] = wr[3];
    expq.delete();
    push_grant(1, -1); push_grant(3, 1);
    push_src(1, 4, 10); push_src(3, 4, 40);
    push_exp(1, 4, 10); push_exp(3, 4, 40);
    @(posedge clk); #1 rst = 1'b0;
    wait_drain(100);

`ifdef ETH_TX_ARB_WATCHDOG_EN
    // Port 0 stalls after 5 beats; watchdog terminates and drains it.
    sent[0]       = 0;
    hold_after[0] = 5;
    push_src(0, 12, 0);
    for (int k = 0; k < 5; k++) expq.push_back({1'b0, 1'b0, beat_dat(0, k)});
    expq.push_back(10'h300);
    push_src(1, 3, 0);
    push_exp(1, 3, 0);
    push_grant(0, -1); push_grant(1, 1);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (watchdog_abort) break;
    end
    chk("watchdog_abort_seen", 32'(watchdog_abort), 32'd1);
    hold_after[0] = -1;
    wait_drain(100);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
